// File: rtl/cache_ri_fill.sv
// +--------------------------------------------------------------------------+
// | cache_ri_fill                                                            |
// | Data-cache line refill: clears the line's readable bits, bursts the line |
// | in from memory, and marks each completed word pair readable.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module cache_ri_fill #(
  parameter int ADDR_WIDTH = 8,
  parameter int LINE_WORDS = 8,
  parameter int MEM_AW     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_lineAddress,
  input  logic [1:0]            req_channel,
  input  logic [MEM_AW-1:0]     req_memAddress,
  output logic                  mem_read,
  output logic [MEM_AW-1:0]     mem_address,
  output logic [7:0]            mem_burstCount,
  input  logic                  mem_waitRequest,
  input  logic                  mem_readDataValid,
  input  logic [31:0]           mem_readData,
  output logic [ADDR_WIDTH-1:0] data_writeAddress,
  output logic [1:0]            data_writeChannel,
  output logic [31:0]           data_writeData,
  output logic                  data_writeEnable,
  output logic [ADDR_WIDTH-1:0] ri_writeAddress,
  output logic [1:0]            ri_writeChannel,
  output logic [7:0]            ri_writeData,
  output logic                  ri_writeEnable,
  output logic                  busy,
  output logic                  done
);

  localparam int                    c_CNT_W     = $clog2(LINE_WORDS);
  localparam logic [c_CNT_W-1:0]    c_LAST_PAIR = c_CNT_W'(LINE_WORDS / 2 - 1);
  localparam logic [c_CNT_W-1:0]    c_LAST_BEAT = c_CNT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] c_LINE_MASK = ADDR_WIDTH'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] c_ONE       = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_REQ   = 3'd2,
    S_RECV  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [1:0]            r_chan;
  logic [MEM_AW-1:0]     r_memAddr;
  logic                  r_reqReady;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_memRead;

  logic [ADDR_WIDTH-1:0] w_beatAddr;
  logic [ADDR_WIDTH-1:0] w_pairAddr;

  assign w_beatAddr = r_base + ADDR_WIDTH'(r_cnt);
  assign w_pairAddr = r_base + ADDR_WIDTH'({r_cnt, 1'b0});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_base     <= '0;
      r_chan     <= '0;
      r_memAddr  <= '0;
      r_reqReady <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_memRead  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_reqReady) begin
            r_base     <= req_lineAddress & ~c_LINE_MASK;
            r_chan     <= req_channel;
            r_memAddr  <= req_memAddress;
            r_cnt      <= '0;
            r_reqReady <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (r_cnt == c_LAST_PAIR) begin
            r_cnt     <= '0;
            r_memRead <= 1'b1;
            r_state   <= S_REQ;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_REQ: begin
          if (!mem_waitRequest) begin
            r_memRead <= 1'b0;
            r_state   <= S_RECV;
          end
        end
        S_RECV: begin
          if (mem_readDataValid) begin
            if (r_cnt == c_LAST_BEAT) begin
              r_cnt   <= '0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_reqReady <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_reqReady <= 1'b1;
          r_busy     <= 1'b0;
          r_memRead  <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  // Beat writes are combinational so a returning word lands in the RAM with no latency.
  always_comb begin
    data_writeEnable  = 1'b0;
    data_writeAddress = '0;
    data_writeData    = '0;
    data_writeChannel = '0;
    ri_writeEnable    = 1'b0;
    ri_writeAddress   = '0;
    ri_writeData      = '0;
    ri_writeChannel   = '0;
    if (r_state == S_CLEAR) begin
      ri_writeEnable  = 1'b1;
      ri_writeAddress = w_pairAddr;
      ri_writeChannel = r_chan;
    end else if (r_state == S_RECV && mem_readDataValid) begin
      data_writeEnable  = 1'b1;
      data_writeAddress = w_beatAddr;
      data_writeData    = mem_readData;
      data_writeChannel = r_chan;
      if (r_cnt[0]) begin
        ri_writeEnable  = 1'b1;
        ri_writeAddress = w_beatAddr - c_ONE;
        ri_writeData    = 8'hFF;
        ri_writeChannel = r_chan;
      end
    end
  end

  assign req_ready      = r_reqReady;
  assign busy           = r_busy;
  assign done           = r_done;
  assign mem_read       = r_memRead;
  assign mem_address    = r_memAddr;
  assign mem_burstCount = 8'(LINE_WORDS);

endmodule

`default_nettype wire

// File: tb/tb_cache_ri_fill.sv
// Self-checking bench for cache_ri_fill: a cycle table for the basic fill,
// then hand-written sequences for waits, gaps, busy requests, reset and spurious beats.
`timescale 1ns/1ps
`default_nettype none

module tb_cache_ri_fill;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [7:0]  req_lineAddress = '0;
  logic [1:0]  req_channel = '0;
  logic [31:0] req_memAddress = '0;
  logic        mem_waitRequest = 1'b0;
  logic        mem_readDataValid = 1'b0;
  logic [31:0] mem_readData = '0;

  logic        req_ready, mem_read, data_writeEnable, ri_writeEnable, busy, done;
  logic [31:0] mem_address, data_writeData;
  logic [7:0]  mem_burstCount, data_writeAddress, ri_writeAddress, ri_writeData;
  logic [1:0]  data_writeChannel, ri_writeChannel;

  always #5 clk = ~clk;

  cache_ri_fill #(.ADDR_WIDTH(8), .LINE_WORDS(8), .MEM_AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_lineAddress(req_lineAddress), .req_channel(req_channel),
    .req_memAddress(req_memAddress),
    .mem_read(mem_read), .mem_address(mem_address), .mem_burstCount(mem_burstCount),
    .mem_waitRequest(mem_waitRequest), .mem_readDataValid(mem_readDataValid),
    .mem_readData(mem_readData),
    .data_writeAddress(data_writeAddress), .data_writeChannel(data_writeChannel),
    .data_writeData(data_writeData), .data_writeEnable(data_writeEnable),
    .ri_writeAddress(ri_writeAddress), .ri_writeChannel(ri_writeChannel),
    .ri_writeData(ri_writeData), .ri_writeEnable(ri_writeEnable),
    .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        rst;
    logic        rv;
    logic [7:0]  line;
    logic [1:0]  ch;
    logic [31:0] ma;
    logic        wt;
    logic        dv;
    logic [31:0] dat;
    logic        rr;
    logic        bsy;
    logic        dn;
    logic        mrd;
    logic [31:0] ema;
    logic        dwe;
    logic [7:0]  da;
    logic [31:0] dd;
    logic [1:0]  dch;
    logic        rwe;
    logic [7:0]  ra;
    logic [7:0]  rdat;
    logic [1:0]  rch;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic [7:0] line, input logic [1:0] ch,
                       input logic [31:0] ma, input logic wt, input logic dv,
                       input logic [31:0] dat);
    @(negedge clk);
    req_valid = rv; req_lineAddress = line; req_channel = ch; req_memAddress = ma;
    mem_waitRequest = wt; mem_readDataValid = dv; mem_readData = dat;
    #4;
  endtask

  task automatic compare(input vec_t v, input int i);
    chk($sformatf("v%0d.ready", i), 32'(req_ready), 32'(v.rr));
    chk($sformatf("v%0d.busy", i), 32'(busy), 32'(v.bsy));
    chk($sformatf("v%0d.done", i), 32'(done), 32'(v.dn));
    chk($sformatf("v%0d.memRead", i), 32'(mem_read), 32'(v.mrd));
    if (v.mrd || !v.rst) chk($sformatf("v%0d.memAddr", i), mem_address, v.ema);
    if (v.mrd) chk($sformatf("v%0d.burst", i), 32'(mem_burstCount), 32'd8);
    chk($sformatf("v%0d.dataWe", i), 32'(data_writeEnable), 32'(v.dwe));
    if (v.dwe) begin
      chk($sformatf("v%0d.dataAddr", i), 32'(data_writeAddress), 32'(v.da));
      chk($sformatf("v%0d.dataData", i), data_writeData, v.dd);
      chk($sformatf("v%0d.dataCh", i), 32'(data_writeChannel), 32'(v.dch));
    end
    chk($sformatf("v%0d.riWe", i), 32'(ri_writeEnable), 32'(v.rwe));
    if (v.rwe) begin
      chk($sformatf("v%0d.riAddr", i), 32'(ri_writeAddress), 32'(v.ra));
      chk($sformatf("v%0d.riData", i), 32'(ri_writeData), 32'(v.rdat));
      chk($sformatf("v%0d.riCh", i), 32'(ri_writeChannel), 32'(v.rch));
    end
  endtask

  task automatic noWrites(input string tag);
    chk({tag, ".dataWe"}, 32'(data_writeEnable), 32'd0);
    chk({tag, ".riWe"}, 32'(ri_writeEnable), 32'd0);
  endtask

  initial begin
    vec_t v;
    vec_t vq[$];

    // Basic fill: line 0x10, channel 2, memory 0x1000, no wait, back-to-back beats.
    v = '0; v.rst = 0; v.rr = 1; vq.push_back(v);
    v = '0; v.rst = 1; v.rv = 1; v.line = 8'h10; v.ch = 2'd2; v.ma = 32'h1000; v.rr = 1;
    vq.push_back(v);
    for (int p = 0; p < 4; p++) begin
      v = '0; v.rst = 1; v.bsy = 1; v.ema = 32'h1000;
      v.rwe = 1; v.ra = 8'(8'h10 + 2 * p); v.rdat = 8'h00; v.rch = 2'd2;
      vq.push_back(v);
    end
    v = '0; v.rst = 1; v.bsy = 1; v.mrd = 1; v.ema = 32'h1000; vq.push_back(v);
    for (int k = 0; k < 8; k++) begin
      v = '0; v.rst = 1; v.dv = 1; v.dat = 32'hD000_0000 + 32'(k); v.bsy = 1; v.ema = 32'h1000;
      v.dwe = 1; v.da = 8'(8'h10 + k); v.dd = v.dat; v.dch = 2'd2;
      if (k % 2 == 1) begin
        v.rwe = 1; v.ra = 8'(8'h10 + k - 1); v.rdat = 8'hFF; v.rch = 2'd2;
      end
      vq.push_back(v);
    end
    v = '0; v.rst = 1; v.bsy = 1; v.dn = 1; v.ema = 32'h1000; vq.push_back(v);
    v = '0; v.rst = 1; v.dv = 1; v.dat = 32'hDEAD_BEEF; v.rr = 1; v.ema = 32'h1000;
    vq.push_back(v);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst_n = vq[i].rst; req_valid = vq[i].rv; req_lineAddress = vq[i].line;
      req_channel = vq[i].ch; req_memAddress = vq[i].ma; mem_waitRequest = vq[i].wt;
      mem_readDataValid = vq[i].dv; mem_readData = vq[i].dat;
      #4;
      compare(vq[i], i);
    end

    // Unaligned request, memory wait, gapped beats, request while busy, held request.
    drive(1, 8'h13, 2'd1, 32'h2000, 1, 0, 0);
    chk("s2.accept.ready", 32'(req_ready), 32'd1);
    for (int p = 0; p < 4; p++) begin
      drive(0, 8'h13, 2'd1, 32'h2000, 1, 0, 0);
      chk($sformatf("s2.clr%0d.riAddr", p), 32'(ri_writeAddress), 32'(8'h10 + 2 * p));
      chk($sformatf("s2.clr%0d.riCh", p), 32'(ri_writeChannel), 32'd1);
    end
    for (int w = 0; w < 3; w++) begin
      drive(0, 8'h13, 2'd1, 32'h2000, 1, 0, 0);
      chk($sformatf("s2.wait%0d.memRead", w), 32'(mem_read), 32'd1);
      chk($sformatf("s2.wait%0d.memAddr", w), mem_address, 32'h2000);
      chk($sformatf("s2.wait%0d.burst", w), 32'(mem_burstCount), 32'd8);
    end
    drive(0, 8'h13, 2'd1, 32'h2000, 0, 0, 0);
    chk("s2.accept.memRead", 32'(mem_read), 32'd1);
    for (int k = 0; k < 8; k++) begin
      drive(0, 8'h13, 2'd1, 32'h2000, 0, 1, 32'hA000_0000 + 32'(k));
      chk($sformatf("s2.b%0d.memRead", k), 32'(mem_read), 32'd0);
      chk($sformatf("s2.b%0d.dataWe", k), 32'(data_writeEnable), 32'd1);
      chk($sformatf("s2.b%0d.dataAddr", k), 32'(data_writeAddress), 32'(8'h10 + k));
      chk($sformatf("s2.b%0d.dataData", k), data_writeData, 32'hA000_0000 + 32'(k));
      chk($sformatf("s2.b%0d.dataCh", k), 32'(data_writeChannel), 32'd1);
      chk($sformatf("s2.b%0d.riWe", k), 32'(ri_writeEnable), 32'(k % 2));
      if (k % 2 == 1) begin
        chk($sformatf("s2.b%0d.riAddr", k), 32'(ri_writeAddress), 32'(8'h10 + k - 1));
        chk($sformatf("s2.b%0d.riData", k), 32'(ri_writeData), 32'hFF);
      end
      if (k < 7) begin
        for (int g = 0; g < 2; g++) begin
          drive((k == 3 && g == 0), 8'h55, 2'd3, 32'h5555, 0, 0, 0);
          noWrites($sformatf("s2.gap%0d_%0d", k, g));
          chk($sformatf("s2.gap%0d_%0d.ready", k, g), 32'(req_ready), 32'd0);
          chk($sformatf("s2.gap%0d_%0d.done", k, g), 32'(done), 32'd0);
        end
      end
    end
    drive(1, 8'h40, 2'd3, 32'h3000, 0, 0, 0);
    chk("s2.done.done", 32'(done), 32'd1);
    chk("s2.done.ready", 32'(req_ready), 32'd0);
    drive(1, 8'h40, 2'd3, 32'h3000, 0, 0, 0);
    chk("s3.idle.ready", 32'(req_ready), 32'd1);
    chk("s3.idle.done", 32'(done), 32'd0);
    chk("s3.idle.busy", 32'(busy), 32'd0);
    drive(0, 8'h40, 2'd3, 32'h3000, 0, 0, 0);
    chk("s3.clr0.busy", 32'(busy), 32'd1);
    chk("s3.clr0.riAddr", 32'(ri_writeAddress), 32'h40);
    chk("s3.clr0.riCh", 32'(ri_writeChannel), 32'd3);

    // Reset part-way through the held fill, after its fourth beat.
    for (int p = 1; p < 4; p++) drive(0, 8'h40, 2'd3, 32'h3000, 0, 0, 0);
    drive(0, 8'h40, 2'd3, 32'h3000, 0, 0, 0);
    chk("s3.req.memAddr", mem_address, 32'h3000);
    for (int k = 0; k < 4; k++) begin
      drive(0, 8'h40, 2'd3, 32'h3000, 0, 1, 32'hB000_0000 + 32'(k));
      chk($sformatf("s3.b%0d.dataAddr", k), 32'(data_writeAddress), 32'(8'h40 + k));
    end
    @(negedge clk);
    rst_n = 1'b0; mem_readDataValid = 1'b1; mem_readData = 32'hB000_0004;
    #4;
    chk("s3.rst.ready", 32'(req_ready), 32'd1);
    chk("s3.rst.busy", 32'(busy), 32'd0);
    chk("s3.rst.memRead", 32'(mem_read), 32'd0);
    chk("s3.rst.memAddr", mem_address, 32'd0);
    noWrites("s3.rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 5; k < 8; k++) begin
      drive(0, 8'h40, 2'd3, 32'h3000, 0, 1, 32'hB000_0000 + 32'(k));
      noWrites($sformatf("s3.late%0d", k));
      chk($sformatf("s3.late%0d.ready", k), 32'(req_ready), 32'd1);
    end

    // Spurious beats in REQ, then a normal fill whose beat counter must start at 0.
    drive(1, 8'h80, 2'd0, 32'h4000, 0, 0, 0);
    for (int p = 0; p < 4; p++) drive(0, 8'h80, 2'd0, 32'h4000, 1, 0, 0);
    drive(0, 8'h80, 2'd0, 32'h4000, 1, 1, 32'hBAD0_0000);
    noWrites("s4.reqWait");
    chk("s4.reqWait.memRead", 32'(mem_read), 32'd1);
    drive(0, 8'h80, 2'd0, 32'h4000, 0, 1, 32'hBAD0_0001);
    noWrites("s4.reqAcc");
    for (int k = 0; k < 8; k++) begin
      drive(0, 8'h80, 2'd0, 32'h4000, 0, 1, 32'hC000_0000 + 32'(k));
      chk($sformatf("s4.b%0d.dataAddr", k), 32'(data_writeAddress), 32'(8'h80 + k));
      chk($sformatf("s4.b%0d.done", k), 32'(done), 32'd0);
    end
    drive(0, 8'h80, 2'd0, 32'h4000, 0, 0, 0);
    chk("s4.done", 32'(done), 32'd1);
    drive(0, 8'h80, 2'd0, 32'h4000, 0, 0, 0);
    chk("s4.after.done", 32'(done), 32'd0);
    chk("s4.after.ready", 32'(req_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cache_ri_fill.md
Name: cache_ri_fill

Overview:
- Line-refill sequencer for the data cache; drives the refill side of the byte-readable (dre) tracking RAM and the data RAM.
- On a miss request it clears the line's readable bits, issues one burst read to memory, and writes each returned word into the data RAM.
- After each completed word pair it marks that pair readable, so the rw side can resume on partially filled lines.

Parameters:
- ADDR_WIDTH, 8, word-address width of the cache RAMs (same as the dre RAM).
- LINE_WORDS, 8, words per cache line; power of two, >=2 (even, so pairs align).
- MEM_AW, 32, memory word-address width.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  refill request
- req_ready  output  1  high only in IDLE
- req_lineAddress  input  ADDR_WIDTH  cache word address of line; low log2(LINE_WORDS) bits ignored and treated as 0
- req_channel  input  2  way/channel to fill
- req_memAddress  input  MEM_AW  memory word address of line start
- mem_read  output  1  burst read request
- mem_address  output  MEM_AW  burst start address
- mem_burstCount  output  8  always LINE_WORDS
- mem_waitRequest  input  1  memory stall; request is accepted when mem_read && !mem_waitRequest
- mem_readDataValid  input  1  return beat valid
- mem_readData  input  32  return beat data
- data_writeAddress  output  ADDR_WIDTH  data RAM word address
- data_writeChannel  output  2  data RAM channel
- data_writeData  output  32  data RAM write data
- data_writeEnable  output  1  data RAM write strobe
- ri_writeAddress  output  ADDR_WIDTH  dre RAM address; bit0 always 0
- ri_writeChannel  output  2  dre RAM channel
- ri_writeData  output  8  readable mask for a word pair
- ri_writeEnable  output  1  dre write strobe
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse when the line is complete

Behaviour:
- Reset: state IDLE; all outputs 0 except req_ready=1. Counters are 0. Captured line address, channel and memory address are 0.
- Reset mid-operation: immediate return to IDLE. The RAMs are not touched, so the line is left partially readable. The memory burst is abandoned; any beats still in flight are ignored in IDLE.
- IDLE:
  - req_valid && req_ready captures the request (line address masked to alignment), clears the counter, and moves to CLEAR.
  - mem_readDataValid is ignored.
- CLEAR:
  - Runs for LINE_WORDS/2 cycles, one per pair p = 0..LINE_WORDS/2-1.
  - Each cycle: ri_writeEnable=1, ri_writeAddress = base + 2p, ri_writeData = 8'h00, ri_writeChannel = captured channel.
  - After the last pair, goes to REQ.
- REQ:
  - mem_read=1, mem_address = captured memory address, mem_burstCount = LINE_WORDS.
  - All three are held stable while mem_waitRequest=1.
  - The cycle with mem_waitRequest=0 accepts the request: next state is RECV and mem_read drops.
  - Beats arriving in REQ are ignored (a compliant memory sends none).
- RECV (beat counter cnt = 0..LINE_WORDS-1):
  - On each mem_readDataValid, in the same cycle (combinational from the beat, zero latency): data_writeEnable=1, data_writeAddress = base + cnt, data_writeData = mem_readData, data_writeChannel = captured channel.
  - If cnt[0]=1, also in the same cycle: ri_writeEnable=1, ri_writeAddress = base + cnt - 1, ri_writeData = 8'hFF.
  - cnt increments per beat. Gaps between beats are allowed; no writes occur in gap cycles.
  - The beat with cnt = LINE_WORDS-1 moves to DONE.
- DONE: done=1 for exactly one cycle, then IDLE; req_ready returns to 1 the following cycle.
- Single outstanding request:
  - req_valid while busy is not accepted.
  - A request held high across DONE is accepted in the next IDLE cycle.
- Minimum latency from request acceptance to done, with no wait and back-to-back beats: 1 (accept) + LINE_WORDS/2 (CLEAR) + 1 (REQ) + LINE_WORDS (RECV) cycles; done is asserted in the following cycle.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; an aligned base never wraps inside a line.
- ri_writeEnable and data_writeEnable are never asserted outside CLEAR/RECV.

Test Plan:
- Basic fill: LINE_WORDS=8, req line 0x10, ch 2, mem 0x1000, no wait, back-to-back beats D0..D7 -> four ri writes of 00 at 0x10/12/14/16; mem_read for 1 cycle at 0x1000 with burst 8; data writes 0x10..0x17 = D0..D7; ri writes FF at 0x10,0x12,0x14,0x16 on beats 1,3,5,7; done pulses once.
- Wait and gaps: mem_waitRequest high 3 cycles, then 2-cycle gaps between beats -> mem_read and mem_address stable during the wait; writes occur only on valid cycles; done comes 1 cycle after the 8th beat.
- Unaligned request: req line 0x13 -> all addresses are based at 0x10.
- Request while busy: req_valid pulsed during RECV -> not accepted, no state change; a held request is accepted 1 cycle after done.
- Reset mid-fill: rst_n low after beat 4 -> outputs go to reset values at once; further beats cause no writes; a new request then completes normally.
- Spurious beat: mem_readDataValid high in IDLE and REQ -> no data or ri writes, counter unchanged.
